// File: rtl/ex_stage_pipe_pkg.sv
// ex_stage_pipe_pkg: shared Y86 execute-stage definitions.
// Holds icode/ifun encodings, jump/cmov condition codes, RNONE, the
// execute FSM state type, the condition-code record and the condition
// evaluation helper used by ex_stage_pipe.
package ex_stage_pipe_pkg;

    // Instruction codes (8-bit to match the decode bus)
    localparam logic [7:0] I_HALT   = 8'h00;
    localparam logic [7:0] I_NOP    = 8'h01;
    localparam logic [7:0] I_RRMOVL = 8'h02;
    localparam logic [7:0] I_IRMOVL = 8'h03;
    localparam logic [7:0] I_RMMOVL = 8'h04;
    localparam logic [7:0] I_MRMOVL = 8'h05;
    localparam logic [7:0] I_OPL    = 8'h06;
    localparam logic [7:0] I_JXX    = 8'h07;
    localparam logic [7:0] I_CALL   = 8'h08;
    localparam logic [7:0] I_RET    = 8'h09;
    localparam logic [7:0] I_PUSHL  = 8'h0A;
    localparam logic [7:0] I_POPL   = 8'h0B;

    // OPL function codes
    localparam logic [7:0] F_ADD  = 8'h00;
    localparam logic [7:0] F_SUB  = 8'h01;
    localparam logic [7:0] F_AND  = 8'h02;
    localparam logic [7:0] F_XOR  = 8'h03;
    localparam logic [7:0] F_MULL = 8'h04;

    // Jump / conditional-move condition codes
    localparam logic [7:0] C_ALWAYS = 8'h00;
    localparam logic [7:0] C_LE     = 8'h01;
    localparam logic [7:0] C_L      = 8'h02;
    localparam logic [7:0] C_E      = 8'h03;
    localparam logic [7:0] C_NE     = 8'h04;
    localparam logic [7:0] C_GE     = 8'h05;
    localparam logic [7:0] C_G      = 8'h06;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_t;

    // Architected condition codes, packed as {ZF,SF,OF}
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = 3'b100;

    // Evaluate a jump/cmov condition against the current condition codes
    function automatic logic cond_eval(input cc_t cc, input logic [7:0] fn);
        logic lt;
        logic res;
        lt  = cc.sf ^ cc.of;
        res = 1'b0;
        case (fn)
            C_ALWAYS: res = 1'b1;
            C_LE:     res = lt | cc.zf;
            C_L:      res = lt;
            C_E:      res = cc.zf;
            C_NE:     res = ~cc.zf;
            C_GE:     res = ~lt;
            C_G:      res = ~lt & ~cc.zf;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst      clock, async active-high reset
//   start         latch operands and clear the accumulator
//   run           allow iteration (held off while the owner waits)
//   a, b          multiplicand / multiplier
//   done_c        last iteration is pending; product_c is the final result
//   product_c     accumulator plus the current partial product (low WORD_W bits)
// Start loads, then WORD_W-1 registered steps; the final step is left
// combinational so the owner can capture it on the WORD_W-th edge. Once done
// the counter saturates and product_c stays stable until the next start.
module ex_mul_iter #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              run,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              done_c,
    output logic [WORD_W-1:0] product_c
);

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] mcand_q;
    logic [WORD_W-1:0] mplier_q;
    logic [WORD_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] partial_c;

    // Low WORD_W bits of the unsigned product equal the two's-complement product
    assign partial_c = mplier_q[0] ? mcand_q : '0;
    assign product_c = acc_q + partial_c;
    assign done_c    = (cnt_q == LAST);

    // Operand shift registers and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (run && !done_c) begin
            acc_q    <= product_c;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: pipelined Y86 execute stage with E/M output register.
// Computes valE for every icode, owns the {ZF,SF,OF} condition codes,
// evaluates jump/cmov conditions and runs MULL on an iterative multiplier.
// Ports:
//   clk, rst                     clock, async active-high reset
//   in_valid / in_ready          decode-side handshake (in_ready is combinational)
//   icode_i, ifun_i              instruction code / function-condition code
//   valA_i, valB_i, valC_i       operands and constant
//   valP_i                       next PC (not needed by execute)
//   dstE_i                       valE destination register
//   flush_i                      drop held result and abort a running MULL
//   out_valid / out_ready        memory-side handshake
//   icode_o, valA_o, valE_o      registered instruction results
//   dstE_o                       registered dstE, RNONE for a not-taken cmov
//   cnd_o                        condition result (1 for non-conditional icodes)
//   inv_o                        invalid OPL function flag
//   cc_o                         architected {ZF,SF,OF}
//   busy_o                       multiplier running
module ex_stage_pipe
    import ex_stage_pipe_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        icode_i,
    input  logic [7:0]        ifun_i,
    input  logic [WORD_W-1:0] valA_i,
    input  logic [WORD_W-1:0] valB_i,
    input  logic [WORD_W-1:0] valC_i,
    input  logic [PC_W-1:0]   valP_i,
    input  logic [3:0]        dstE_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        icode_o,
    output logic [WORD_W-1:0] valA_o,
    output logic [WORD_W-1:0] valE_o,
    output logic [3:0]        dstE_o,
    output logic              cnd_o,
    output logic              inv_o,
    output logic [2:0]        cc_o,
    output logic              busy_o
);

    localparam int unsigned     MSB  = WORD_W - 1;
    localparam logic [WORD_W-1:0] FOUR = WORD_W'(4);

    ex_state_t         state_q;
    cc_t               cc_q;
    logic [WORD_W-1:0] pend_vala_q;
    logic [3:0]        pend_dste_q;

    logic              is_opl_c;
    logic              is_cmov_c;
    logic              is_jxx_c;
    logic              fn_ok_c;
    logic              is_mul_c;
    logic              out_free_c;
    logic              accept_c;
    logic              mul_fin_c;
    logic              cnd_c;
    logic [WORD_W-1:0] alu_c;
    cc_t               opl_cc_c;
    cc_t               mul_cc_c;
    logic              mul_done_c;
    logic [WORD_W-1:0] mul_product_c;
    logic              unused_valp;

    // valP passes around execute; reduce it so it is visibly consumed
    assign unused_valp = ^valP_i;

    assign is_opl_c   = (icode_i == I_OPL);
    assign is_cmov_c  = (icode_i == I_RRMOVL);
    assign is_jxx_c   = (icode_i == I_JXX);
    assign fn_ok_c    = (ifun_i <= F_XOR) || (MUL_EN && (ifun_i == F_MULL));
    assign is_mul_c   = is_opl_c && MUL_EN && (ifun_i == F_MULL);

    assign out_free_c = !out_valid || out_ready;
    assign in_ready   = !flush_i && (state_q == ST_IDLE) && out_free_c;
    assign accept_c   = in_valid && in_ready;
    assign mul_fin_c  = (state_q == ST_MUL) && mul_done_c && out_free_c && !flush_i;

    assign cnd_c      = (is_jxx_c || is_cmov_c) ? cond_eval(cc_q, ifun_i) : 1'b1;
    assign cc_o       = cc_q;

    // valE for every instruction class
    always_comb begin
        alu_c = '0;
        case (icode_i)
            I_OPL: begin
                case (ifun_i)
                    F_ADD:   alu_c = valB_i + valA_i;
                    F_SUB:   alu_c = valB_i - valA_i;
                    F_AND:   alu_c = valB_i & valA_i;
                    F_XOR:   alu_c = valB_i ^ valA_i;
                    default: alu_c = '0;
                endcase
            end
            I_RRMOVL:         alu_c = valA_i;
            I_IRMOVL:         alu_c = valC_i;
            I_RMMOVL,
            I_MRMOVL:         alu_c = valB_i + valC_i;
            I_PUSHL, I_CALL:  alu_c = valB_i - FOUR;
            I_POPL, I_RET:    alu_c = valB_i + FOUR;
            default:          alu_c = '0;
        endcase
    end

    // Flags for a single-cycle OPL result
    always_comb begin
        opl_cc_c    = '0;
        opl_cc_c.zf = (alu_c == '0);
        opl_cc_c.sf = alu_c[MSB];
        case (ifun_i)
            F_ADD:   opl_cc_c.of = (valA_i[MSB] == valB_i[MSB]) && (alu_c[MSB] != valA_i[MSB]);
            F_SUB:   opl_cc_c.of = (valA_i[MSB] != valB_i[MSB]) && (alu_c[MSB] != valB_i[MSB]);
            default: opl_cc_c.of = 1'b0;
        endcase
    end

    // Flags for a completing MULL (never overflows architecturally)
    always_comb begin
        mul_cc_c    = '0;
        mul_cc_c.zf = (mul_product_c == '0);
        mul_cc_c.sf = mul_product_c[MSB];
    end

    ex_mul_iter #(
        .WORD_W (WORD_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (accept_c && is_mul_c),
        .run       (state_q == ST_MUL),
        .a         (valA_i),
        .b         (valB_i),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );

    // FSM, condition codes and E/M output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_o      <= 1'b0;
            out_valid   <= 1'b0;
            icode_o     <= '0;
            valA_o      <= '0;
            valE_o      <= '0;
            dstE_o      <= '0;
            cnd_o       <= 1'b0;
            inv_o       <= 1'b0;
            cc_q        <= CC_RESET;
            pend_vala_q <= '0;
            pend_dste_q <= '0;
        end else if (flush_i) begin
            // Drop the held result and any MULL in flight; CCs stay as written
            state_q   <= ST_IDLE;
            busy_o    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c && is_mul_c) begin
                        state_q     <= ST_MUL;
                        busy_o      <= 1'b1;
                        pend_vala_q <= valA_i;
                        pend_dste_q <= dstE_i;
                    end
                end
                ST_MUL: begin
                    if (mul_fin_c) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase

            if (accept_c && !is_mul_c) begin
                out_valid <= 1'b1;
                icode_o   <= icode_i;
                valA_o    <= valA_i;
                valE_o    <= alu_c;
                dstE_o    <= (is_cmov_c && !cnd_c) ? RNONE : dstE_i;
                cnd_o     <= cnd_c;
                inv_o     <= is_opl_c && !fn_ok_c;
                if (is_opl_c && fn_ok_c) begin
                    cc_q <= opl_cc_c;
                end
            end else if (mul_fin_c) begin
                out_valid <= 1'b1;
                icode_o   <= I_OPL;
                valA_o    <= pend_vala_q;
                valE_o    <= mul_product_c;
                dstE_o    <= pend_dste_q;
                cnd_o     <= 1'b1;
                inv_o     <= 1'b0;
                cc_q      <= mul_cc_c;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed self-checking bench for ex_stage_pipe.
module tb_ex_stage_pipe;

    localparam logic [7:0] OPL = 8'h06, RRM = 8'h02, IRM = 8'h03, RMM = 8'h04;
    localparam logic [7:0] JXX = 8'h07, PSH = 8'h0A, NOP = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush_i, out_valid, out_ready;
    logic [7:0]  icode_i, ifun_i, icode_o;
    logic [31:0] valA_i, valB_i, valC_i, valP_i, valA_o, valE_o;
    logic [3:0]  dstE_i, dstE_o;
    logic        cnd_o, inv_o, busy_o;
    logic [2:0]  cc_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_stage_pipe #(.WORD_W(32), .PC_W(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode_i(icode_i), .ifun_i(ifun_i), .valA_i(valA_i), .valB_i(valB_i),
        .valC_i(valC_i), .valP_i(valP_i), .dstE_i(dstE_i), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready), .icode_o(icode_o),
        .valA_o(valA_o), .valE_o(valE_o), .dstE_o(dstE_o), .cnd_o(cnd_o),
        .inv_o(inv_o), .cc_o(cc_o), .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] ic, input logic [7:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [3:0] d);
        icode_i = ic; ifun_i = fn; valA_i = a; valB_i = b; valC_i = c; dstE_i = d;
        valP_i = 32'h40;
    endtask

    // Offer one instruction for a single edge (caller guarantees in_ready)
    task automatic send(input logic [7:0] ic, input logic [7:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [3:0] d);
        drive(ic, fn, a, b, c, d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
        drive(NOP, 8'h00, 32'h0, 32'h0, 32'h0, 4'h0);
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (valE_o !== 32'h0) begin n_bad++; $display("FAIL reset_valE: got %h want 0", valE_o); end
        n_cmp++; if (cc_o !== 3'b100) begin n_bad++; $display("FAIL reset_cc: got %b want 100", cc_o); end
        n_cmp++; if ({cnd_o, inv_o, busy_o} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {cnd_o, inv_o, busy_o}); end
        rst = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_sub_zero();
        send(OPL, 8'h01, 32'd5, 32'd5, 32'h0, 4'h1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sub_latency: got %b want 1", out_valid); end
        n_cmp++; if (valE_o !== 32'h0) begin n_bad++; $display("FAIL sub_valE: got %h want 0", valE_o); end
        n_cmp++; if (cc_o !== 3'b100) begin n_bad++; $display("FAIL sub_cc: got %b want 100", cc_o); end
        // cmov E taken with ZF=1
        send(RRM, 8'h03, 32'h55, 32'h0, 32'h0, 4'h3);
        n_cmp++; if ({cnd_o, dstE_o} !== 5'b1_0011) begin n_bad++; $display("FAIL cmove_taken: got %b want 10011", {cnd_o, dstE_o}); end
        n_cmp++; if (valE_o !== 32'h55) begin n_bad++; $display("FAIL cmove_valE: got %h want 55", valE_o); end
        // condition code above 6 is never true
        send(JXX, 8'h07, 32'h1, 32'h2, 32'h3, 4'hF);
        n_cmp++; if ({cnd_o, valE_o} !== 33'h0) begin n_bad++; $display("FAIL jxx_cc7: got cnd %b valE %h want 0 0", cnd_o, valE_o); end
    endtask

    task automatic test_add_overflow();
        send(OPL, 8'h00, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'h2);
        n_cmp++; if (valE_o !== 32'h8000_0000) begin n_bad++; $display("FAIL add_valE: got %h want 80000000", valE_o); end
        n_cmp++; if (cc_o !== 3'b011) begin n_bad++; $display("FAIL add_cc: got %b want 011", cc_o); end
        send(JXX, 8'h02, 32'h0, 32'h0, 32'h0, 4'hF);
        n_cmp++; if (cnd_o !== 1'b0) begin n_bad++; $display("FAIL jl_cnd: got %b want 0", cnd_o); end
        send(RRM, 8'h01, 32'h9, 32'h0, 32'h0, 4'h3);
        n_cmp++; if (cnd_o !== 1'b0) begin n_bad++; $display("FAIL cmovle_cnd: got %b want 0", cnd_o); end
        n_cmp++; if (dstE_o !== 4'hF) begin n_bad++; $display("FAIL cmovle_dstE: got %h want f", dstE_o); end
    endtask

    task automatic test_mull();
        int errs = 0;
        send(OPL, 8'h04, 32'hFFFF_FFFD, 32'h7, 32'h0, 4'h5);
        for (int i = 0; i < 32; i++) begin
            if (!(busy_o === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0)) errs++;
            tick();
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL mull_busy_window: got %0d bad cycles want 0", errs); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mull_latency: got %b want 1", out_valid); end
        n_cmp++; if (valE_o !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mull_valE: got %h want ffffffeb", valE_o); end
        n_cmp++; if (cc_o !== 3'b010) begin n_bad++; $display("FAIL mull_cc: got %b want 010", cc_o); end
        n_cmp++; if ({busy_o, dstE_o} !== 5'b0_0101) begin n_bad++; $display("FAIL mull_done: got %b want 00101", {busy_o, dstE_o}); end
    endtask

    task automatic test_backpressure();
        int errs = 0;
        send(IRM, 8'h00, 32'h0, 32'h0, 32'h1234, 4'h2);
        n_cmp++; if (valE_o !== 32'h1234) begin n_bad++; $display("FAIL irmovl_valE: got %h want 1234", valE_o); end
        out_ready = 1'b0;
        drive(RMM, 8'h00, 32'h0, 32'h100, 32'h20, 4'h6);
        in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b want 0", in_ready); end
        repeat (3) begin
            tick();
            if (!(out_valid === 1'b1 && valE_o === 32'h1234 && dstE_o === 4'h2 && in_ready === 1'b0)) errs++;
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d bad cycles want 0", errs); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, valE_o} !== {1'b1, 32'h120}) begin n_bad++; $display("FAIL bp_reload: got %b %h want 1 120", out_valid, valE_o); end
    endtask

    task automatic test_flush_mul();
        int errs = 0;
        send(OPL, 8'h04, 32'h2, 32'h3, 32'h0, 4'h1);
        repeat (9) tick();
        flush_i = 1'b1;
        drive(NOP, 8'h00, 32'h0, 32'h0, 32'h0, 4'hF);
        in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_block: got %b want 0", in_ready); end
        tick();
        flush_i = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({busy_o, out_valid} !== 2'b00) begin n_bad++; $display("FAIL flush_abort: got %b want 00", {busy_o, out_valid}); end
        n_cmp++; if (cc_o !== 3'b010) begin n_bad++; $display("FAIL flush_cc: got %b want 010", cc_o); end
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) errs++;
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL flush_quiet: got %0d valid cycles want 0", errs); end
        send(PSH, 8'h00, 32'h0, 32'h100, 32'h0, 4'h4);
        n_cmp++; if ({out_valid, valE_o} !== {1'b1, 32'hFC}) begin n_bad++; $display("FAIL pushl_valE: got %b %h want 1 fc", out_valid, valE_o); end
        n_cmp++; if (cnd_o !== 1'b1) begin n_bad++; $display("FAIL pushl_cnd: got %b want 1", cnd_o); end
    endtask

    task automatic test_invalid();
        send(OPL, 8'h05, 32'h1, 32'h2, 32'h0, 4'h3);
        n_cmp++; if ({inv_o, valE_o} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL inv_flag: got %b %h want 1 0", inv_o, valE_o); end
        n_cmp++; if (cc_o !== 3'b010) begin n_bad++; $display("FAIL inv_cc: got %b want 010", cc_o); end
        send(OPL, 8'h03, 32'hF0, 32'hFF, 32'h0, 4'h3);
        n_cmp++; if ({inv_o, valE_o} !== {1'b0, 32'h0F}) begin n_bad++; $display("FAIL xor_valE: got %b %h want 0 f", inv_o, valE_o); end
        n_cmp++; if (cc_o !== 3'b000) begin n_bad++; $display("FAIL xor_cc: got %b want 000", cc_o); end
    endtask

    task automatic test_async_reset();
        send(IRM, 8'h00, 32'h0, 32'h0, 32'hABC, 4'h2);
        out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        n_cmp++; if (cc_o !== 3'b100) begin n_bad++; $display("FAIL arst_cc: got %b want 100", cc_o); end
        n_cmp++; if (valE_o !== 32'h0) begin n_bad++; $display("FAIL arst_valE: got %h want 0", valE_o); end
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_sub_zero();
        test_add_overflow();
        test_mull();
        test_backpressure();
        test_flush_mul();
        test_invalid();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
